// File: rtl/exec_core.sv
// Multi-cycle execution core: fetches 16-bit instructions as two bytes over a
// req/ack memory port, decodes them from isa_pkg, executes in one cycle and
// performs a separate memory phase for LOAD/STORE.

package isa_pkg;
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_MOVIR = 4'h1;
   localparam logic [3:0] OP_MOVRR = 4'h2;
   localparam logic [3:0] OP_ADDRR = 4'h3;
   localparam logic [3:0] OP_SUBRR = 4'h4;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_SUBI  = 4'h6;
   localparam logic [3:0] OP_LOAD  = 4'h7;
   localparam logic [3:0] OP_STORE = 4'h8;
   localparam logic [3:0] OP_JZI   = 4'h9;
   localparam logic [3:0] OP_JZR   = 4'hA;
endpackage

module exec_core
   import isa_pkg::*;
#(
   parameter int          DATA_BITS     = 8,
   parameter int          REG_ADDR_BITS = 3,
   parameter int          ADDR_BITS     = 8,
   parameter int unsigned RESET_PC      = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   input  logic                 mem_ack,
   input  logic [DATA_BITS-1:0] mem_rdata,
   output logic [ADDR_BITS-1:0] pc_o,
   output logic                 flag_z,
   output logic                 flag_c,
   output logic                 halted
);

   localparam int NUM_REGS = 2 ** REG_ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH_HI = 3'd1,
      S_FETCH_LO = 3'd2,
      S_EXECUTE  = 3'd3,
      S_MEM      = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   pc_q, pc_d;
   logic [15:0]            ir_q, ir_d;
   logic [DATA_BITS-1:0]   regs_q [NUM_REGS];
   logic [DATA_BITS-1:0]   regs_d [NUM_REGS];
   logic                   flag_z_q, flag_z_d;
   logic                   flag_c_q, flag_c_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_BITS-1:0]   mem_wdata_q, mem_wdata_d;
   logic                   halted_q, halted_d;

   // Decoded instruction fields
   logic [3:0]               op;
   logic [REG_ADDR_BITS-1:0] rd_idx, rs_idx, rt_idx;
   logic [DATA_BITS-1:0]     imm_ext, rd_val, rs_val, rt_val;
   logic [ADDR_BITS-1:0]     imm_addr, pc_plus1, pc_plus2;
   logic                     unused_ir_bit;

   // ALU operands and result; the extra MSB is the carry out
   logic [DATA_BITS-1:0]     alu_a, alu_b, alu_b_eff;
   logic                     alu_sub;
   logic [DATA_BITS:0]       alu_sum;

   assign op            = ir_q[15:12];
   assign rd_idx        = REG_ADDR_BITS'(ir_q[10:8]);
   assign rs_idx        = REG_ADDR_BITS'(ir_q[6:4]);
   assign rt_idx        = REG_ADDR_BITS'(ir_q[2:0]);
   assign imm_ext       = DATA_BITS'(ir_q[7:0]);
   assign imm_addr      = ADDR_BITS'(ir_q[7:0]);
   assign rd_val        = regs_q[rd_idx];
   assign rs_val        = regs_q[rs_idx];
   assign rt_val        = regs_q[rt_idx];
   assign pc_plus1      = pc_q + ADDR_BITS'(1);
   assign pc_plus2      = pc_q + ADDR_BITS'(2);
   assign unused_ir_bit = ir_q[11];

   // ALU: register-register forms use rs/rt, immediate forms use rd/imm; SUB is a+~b+1
   always_comb begin
      alu_a   = rs_val;
      alu_b   = rt_val;
      alu_sub = 1'b0;
      case (op)
         OP_ADDRR: alu_sub = 1'b0;
         OP_SUBRR: alu_sub = 1'b1;
         OP_ADDI: begin
            alu_a = rd_val;
            alu_b = imm_ext;
         end
         OP_SUBI: begin
            alu_a   = rd_val;
            alu_b   = imm_ext;
            alu_sub = 1'b1;
         end
         default: alu_sub = 1'b0;
      endcase
      alu_b_eff = alu_sub ? ~alu_b : alu_b;
      alu_sum   = {1'b0, alu_a} + {1'b0, alu_b_eff} + {{DATA_BITS{1'b0}}, alu_sub};
   end

   // Next-state logic for the sequencer, memory port, regfile, flags and pc
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      regs_d      = regs_q;
      flag_z_d    = flag_z_q;
      flag_c_d    = flag_c_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      halted_d    = halted_q;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d  = S_FETCH_HI;
               halted_d = 1'b0;
            end else begin
               halted_d = 1'b1;
            end
         end
         S_FETCH_HI: begin
            if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = pc_q;
            end else if (mem_ack) begin
               ir_d[15:8] = mem_rdata[7:0];
               mem_req_d  = 1'b0;
               state_d    = S_FETCH_LO;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         S_FETCH_LO: begin
            if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = pc_plus1;
            end else if (mem_ack) begin
               ir_d[7:0] = mem_rdata[7:0];
               mem_req_d = 1'b0;
               state_d   = S_EXECUTE;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         S_EXECUTE: begin
            pc_d = pc_plus2;
            case (op)
               OP_MOVIR: regs_d[rd_idx] = imm_ext;
               OP_MOVRR: regs_d[rd_idx] = rs_val;
               OP_ADDRR, OP_SUBRR, OP_ADDI, OP_SUBI: begin
                  regs_d[rd_idx] = alu_sum[DATA_BITS-1:0];
                  flag_c_d       = alu_sum[DATA_BITS];
                  flag_z_d       = (alu_sum[DATA_BITS-1:0] == {DATA_BITS{1'b0}});
               end
               OP_JZI: begin
                  if (flag_z_q) begin
                     pc_d = imm_addr;
                  end else begin
                     pc_d = pc_plus2;
                  end
               end
               OP_JZR: begin
                  if (flag_z_q) begin
                     pc_d = ADDR_BITS'(rd_val);
                  end else begin
                     pc_d = pc_plus2;
                  end
               end
               default: pc_d = pc_plus2;
            endcase
            if ((op == OP_LOAD) || (op == OP_STORE)) begin
               state_d = S_MEM;
            end else if (run) begin
               state_d = S_FETCH_HI;
            end else begin
               state_d  = S_IDLE;
               halted_d = 1'b1;
            end
         end
         S_MEM: begin
            if (!mem_req_q) begin
               mem_req_d   = 1'b1;
               mem_we_d    = (op == OP_STORE);
               mem_addr_d  = imm_addr;
               mem_wdata_d = rd_val;
            end else if (mem_ack) begin
               if (!mem_we_q) begin
                  regs_d[rd_idx] = mem_rdata;
               end else begin
                  regs_d[rd_idx] = rd_val;
               end
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (run) begin
                  state_d = S_FETCH_HI;
               end else begin
                  state_d  = S_IDLE;
                  halted_d = 1'b1;
               end
            end else begin
               mem_req_d = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            halted_d  = 1'b1;
         end
      endcase
   end

   // State registers; reset drops the memory request asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= ADDR_BITS'(RESET_PC);
         ir_q        <= 16'h0000;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= {DATA_BITS{1'b0}};
         end
         flag_z_q    <= 1'b0;
         flag_c_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_BITS{1'b0}};
         mem_wdata_q <= {DATA_BITS{1'b0}};
         halted_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         regs_q      <= regs_d;
         flag_z_q    <= flag_z_d;
         flag_c_q    <= flag_c_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         halted_q    <= halted_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign pc_o      = pc_q;
   assign flag_z    = flag_z_q;
   assign flag_c    = flag_c_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_exec_core.sv
// Directed bench for exec_core: a byte memory responder with configurable ack
// delay checks every request against a scoreboard of expected requests.

module tb_exec_core;
   import isa_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] pc_o;
   logic       flag_z;
   logic       flag_c;
   logic       halted;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } req_t;

   req_t       exp_q[$];
   logic [7:0] mem [256];
   int         max_delay = 0;
   logic       hold_ack  = 1'b0;

   exec_core dut (
      .clk(clk), .reset(reset), .run(run),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .pc_o(pc_o), .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ins_ri(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
      return {op, 1'b0, rd, imm};
   endfunction

   function automatic logic [15:0] ins_rrr(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [2:0] rt);
      return {op, 1'b0, rd, 1'b0, rs, 1'b0, rt};
   endfunction

   task automatic put(input logic [7:0] a, input logic [15:0] w);
      logic [7:0] a1;
      a1 = a + 8'd1;
      mem[a]  = w[15:8];
      mem[a1] = w[7:0];
   endtask

   task automatic push_fetch(input logic [7:0] a);
      logic [7:0] a1;
      a1 = a + 8'd1;
      exp_q.push_back('{we: 1'b0, addr: a,  wdata: 8'h00});
      exp_q.push_back('{we: 1'b0, addr: a1, wdata: 8'h00});
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back('{we: 1'b1, addr: a, wdata: d});
   endtask

   task automatic push_rd(input logic [7:0] a);
      exp_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
   endtask

   task automatic wait_req(input logic [7:0] a, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (mem_req && (mem_addr == a)) begin
            found = 1'b1;
            break;
         end
      end
      check(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_halted(input string tag);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (halted) break;
      end
      check(tag, 32'(halted), 32'd1);
   endtask

   // Memory responder: scoreboard compare on each new request, hold checks while waiting
   logic       rsp_active = 1'b0;
   int         rsp_delay  = 0;
   logic       cur_we;
   logic [7:0] cur_addr;
   logic [7:0] cur_wdata;
   req_t       e;

   task automatic give_ack();
      mem_ack = 1'b1;
      if (cur_we) mem[cur_addr] = cur_wdata;
      else        mem_rdata = mem[cur_addr];
   endtask

   always @(negedge clk) begin
      if (reset) begin
         mem_ack    = 1'b0;
         rsp_active = 1'b0;
      end else if (mem_ack) begin
         mem_ack    = 1'b0;
         rsp_active = 1'b0;
         mem_rdata  = 8'($urandom);
      end else if (mem_req && !rsp_active) begin
         rsp_active = 1'b1;
         cur_we     = mem_we;
         cur_addr   = mem_addr;
         cur_wdata  = mem_wdata;
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_req observed addr=%h we=%b expected no request", mem_addr, mem_we);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("req_we", 32'(mem_we), 32'(e.we));
            check("req_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) check("req_wdata", 32'(mem_wdata), 32'(e.wdata));
         end
         rsp_delay = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
         if (!hold_ack && (rsp_delay == 0)) give_ack();
      end else if (rsp_active) begin
         check("hold_req", 32'(mem_req), 32'd1);
         check("hold_we", 32'(mem_we), 32'(cur_we));
         check("hold_addr", 32'(mem_addr), 32'(cur_addr));
         if (cur_we) check("hold_wdata", 32'(mem_wdata), 32'(cur_wdata));
         if (!hold_ack) begin
            if (rsp_delay > 0) rsp_delay--;
            if (rsp_delay == 0) give_ack();
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset = 1'b1;
      run   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_halted", 32'(halted), 32'd1);
      check("rst_pc", 32'(pc_o), 32'd0);
      check("rst_flags", 32'({flag_z, flag_c}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Program 1: 0-wait memory, ALU/flags, taken and not-taken jumps, pc wrap
      put(8'h00, ins_ri(OP_MOVIR, 3'd1, 8'h05));
      put(8'h02, ins_ri(OP_MOVIR, 3'd2, 8'h03));
      put(8'h04, ins_rrr(OP_SUBRR, 3'd3, 3'd1, 3'd2));
      put(8'h06, ins_ri(OP_STORE, 3'd3, 8'h30));
      put(8'h08, ins_rrr(OP_SUBRR, 3'd3, 3'd1, 3'd1));
      put(8'h0A, ins_ri(OP_JZI, 3'd0, 8'h40));
      put(8'h40, ins_ri(OP_MOVIR, 3'd1, 8'h01));
      put(8'h42, ins_ri(OP_ADDI, 3'd1, 8'hFF));
      put(8'h44, ins_ri(OP_STORE, 3'd1, 8'h31));
      put(8'h46, ins_ri(OP_MOVIR, 3'd5, 8'h07));
      put(8'h48, ins_ri(OP_ADDI, 3'd5, 8'h01));
      put(8'h4A, ins_ri(OP_JZI, 3'd0, 8'h10));
      put(8'h4C, ins_ri(OP_SUBI, 3'd5, 8'h08));
      put(8'h4E, ins_ri(OP_MOVIR, 3'd7, 8'hFE));
      put(8'h50, ins_ri(OP_JZR, 3'd7, 8'h00));
      put(8'hFE, ins_ri(OP_NOP, 3'd0, 8'h00));
      mem[8'h31] = 8'hEE;
      push_fetch(8'h00); push_fetch(8'h02); push_fetch(8'h04); push_fetch(8'h06);
      push_wr(8'h30, 8'h02);
      push_fetch(8'h08); push_fetch(8'h0A); push_fetch(8'h40); push_fetch(8'h42);
      push_fetch(8'h44);
      push_wr(8'h31, 8'h00);
      push_fetch(8'h46); push_fetch(8'h48); push_fetch(8'h4A); push_fetch(8'h4C);
      push_fetch(8'h4E); push_fetch(8'h50); push_fetch(8'hFE);
      run = 1'b1;
      wait_req(8'h06, "reach_06");
      check("sub_5_3_zc", 32'({flag_z, flag_c}), 32'b01);
      check("pc_at_06", 32'(pc_o), 32'h06);
      wait_req(8'h0A, "reach_0A");
      check("sub_self_zc", 32'({flag_z, flag_c}), 32'b11);
      wait_req(8'h40, "jzi_taken");
      wait_req(8'h44, "reach_44");
      check("addi_ff_zc", 32'({flag_z, flag_c}), 32'b11);
      wait_req(8'h4A, "reach_4A");
      check("addi_7_1_zc", 32'({flag_z, flag_c}), 32'b00);
      wait_req(8'h4C, "jzi_not_taken");
      wait_req(8'h4E, "reach_4E");
      check("subi_zc", 32'({flag_z, flag_c}), 32'b11);
      wait_req(8'hFF, "fetch_lo_FF");
      run = 1'b0;
      wait_halted("halt_after_wrap");
      check("pc_wrapped", 32'(pc_o), 32'h00);
      check("nop_flags", 32'({flag_z, flag_c}), 32'b11);
      check("store_r3", 32'(mem[8'h30]), 32'h02);
      check("store_r1_zero", 32'(mem[8'h31]), 32'h00);
      check("q_empty_1", 32'(exp_q.size()), 32'd0);

      // Program 2: random 0..5 ack delay, store/load round trip, resume at pc 00
      max_delay = 5;
      put(8'h00, ins_ri(OP_MOVIR, 3'd1, 8'hA5));
      put(8'h02, ins_ri(OP_STORE, 3'd1, 8'h20));
      put(8'h04, ins_ri(OP_LOAD, 3'd4, 8'h20));
      put(8'h06, ins_ri(OP_STORE, 3'd4, 8'h21));
      put(8'h08, ins_rrr(OP_ADDRR, 3'd0, 3'd4, 3'd4));
      put(8'h0A, ins_ri(OP_STORE, 3'd0, 8'h22));
      mem[8'h20] = 8'h00; mem[8'h21] = 8'h00; mem[8'h22] = 8'h00;
      push_fetch(8'h00); push_fetch(8'h02);
      push_wr(8'h20, 8'hA5);
      push_fetch(8'h04);
      push_rd(8'h20);
      push_fetch(8'h06);
      push_wr(8'h21, 8'hA5);
      push_fetch(8'h08); push_fetch(8'h0A);
      push_wr(8'h22, 8'h4A);
      run = 1'b1;
      wait_req(8'h0B, "fetch_lo_0B");
      run = 1'b0;
      wait_halted("halt_after_store");
      check("pc_after_p2", 32'(pc_o), 32'h0C);
      check("addrr_zc", 32'({flag_z, flag_c}), 32'b01);
      check("mem20", 32'(mem[8'h20]), 32'hA5);
      check("load_r4", 32'(mem[8'h21]), 32'hA5);
      check("addrr_sum", 32'(mem[8'h22]), 32'h4A);
      check("q_empty_2", 32'(exp_q.size()), 32'd0);

      // Reset while a request waits for ack
      max_delay = 0;
      hold_ack  = 1'b1;
      push_fetch(8'h0C);
      run = 1'b1;
      wait_req(8'h0C, "req_before_reset");
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_drop_req", 32'(mem_req), 32'd0);
      check("rst_mid_halted", 32'(halted), 32'd1);
      check("rst_mid_pc", 32'(pc_o), 32'h00);
      check("rst_mid_flags", 32'({flag_z, flag_c}), 32'd0);
      run = 1'b0;
      @(negedge clk);
      exp_q.delete();
      hold_ack = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      check("post_rst_halted", 32'(halted), 32'd1);
      check("post_rst_req", 32'(mem_req), 32'd0);

      // Registers must be cleared by reset: store r1 from pc 00
      put(8'h00, ins_ri(OP_STORE, 3'd1, 8'h23));
      mem[8'h23] = 8'hFF;
      push_fetch(8'h00);
      push_wr(8'h23, 8'h00);
      run = 1'b1;
      wait_req(8'h01, "fetch_lo_01");
      run = 1'b0;
      wait_halted("halt_after_rst_store");
      check("pc_after_p3", 32'(pc_o), 32'h02);
      check("reg_cleared", 32'(mem[8'h23]), 32'h00);
      check("q_empty_3", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
